// File: rtl/cam_pixel_capture_if.sv
// Camera-side byte stream and the assembled pixel stream that leaves the capture block.
interface cam_pixel_capture_if #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int CNT_W         = 12
);
  logic [DATA_W-1:0]               CAM_DATA;
  logic                            HREF;
  logic                            VSYNC;
  logic [DATA_W*BYTES_PER_PIX-1:0] o_pixel;
  logic                            o_valid;
  logic [CNT_W-1:0]                o_x;
  logic [CNT_W-1:0]                o_y;
  logic                            o_sof;
  logic                            o_eol;

  modport master (
    output CAM_DATA, HREF, VSYNC,
    input  o_pixel, o_valid, o_x, o_y, o_sof, o_eol
  );

  modport slave (
    input  CAM_DATA, HREF, VSYNC,
    output o_pixel, o_valid, o_x, o_y, o_sof, o_eol
  );
endinterface

// File: rtl/cam_pixel_capture.sv
// Packs BYTES_PER_PIX sensor bytes into pixels under VSYNC/HREF framing, applies a
// per-frame crop window and reports frame/line markers, framing errors and a frame count.
module cam_pixel_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int BYTE_SWAP     = 0,
  parameter int CNT_W         = 12
) (
  input  logic                 i_pclk,
  input  logic                 i_rst_n,
  cam_pixel_capture_if.slave   cam,
  input  logic                 i_enable,
  input  logic [CNT_W-1:0]     i_x_start,
  input  logic [CNT_W-1:0]     i_x_end,
  input  logic [CNT_W-1:0]     i_y_start,
  input  logic [CNT_W-1:0]     i_y_end,
  output logic                 o_eof,
  output logic                 o_line_err,
  output logic [15:0]          o_frame_cnt
);

  localparam int              PIX_W    = DATA_W * BYTES_PER_PIX;
  localparam int              IDX_W    = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PIX - 1);

  typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE, SKIP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
  logic               sof_pend_q, sof_pend_d;
  logic               href_q;
  logic [PIX_W-1:0]   acc_q, acc_d, asm_pix;
  logic [CNT_W-1:0]   xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic [CNT_W-1:0]   px_q, px_d, py_q, py_d;
  logic               valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic               eof_q, eof_d, lerr_q, lerr_d;
  logic [15:0]        fcnt_q, fcnt_d;
  logic               in_win;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_win = (x_q >= xs_q) && (x_q <= xe_q) && (y_q >= ys_q) && (y_q <= ye_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    x_d        = x_q;
    y_d        = y_q;
    sof_pend_d = sof_pend_q;
    acc_d      = acc_q;
    xs_d       = xs_q;
    xe_d       = xe_q;
    ys_d       = ys_q;
    ye_d       = ye_q;
    pixel_d    = pixel_q;
    px_d       = px_q;
    py_d       = py_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eol_d      = 1'b0;
    eof_d      = 1'b0;
    lerr_d     = 1'b0;
    fcnt_d     = fcnt_q;

    // Slot 0 lands in the MSBs unless the byte order is swapped.
    asm_pix = acc_q;
    for (int s = 0; s < BYTES_PER_PIX; s++) begin
      if (idx_q == IDX_W'(s))
        asm_pix[((BYTE_SWAP != 0) ? s : (BYTES_PER_PIX - 1 - s)) * DATA_W +: DATA_W] = cam.CAM_DATA;
    end

    case (state_q)
      SYNC: begin
        if (cam.VSYNC) state_d = VBLANK;
      end
      VBLANK: begin
        if (!cam.VSYNC) begin
          if (i_enable) begin
            state_d    = ACTIVE;
            xs_d       = i_x_start;
            xe_d       = i_x_end;
            ys_d       = i_y_start;
            ye_d       = i_y_end;
            x_d        = '0;
            y_d        = '0;
            idx_d      = '0;
            sof_pend_d = 1'b1;
          end else begin
            state_d = SKIP;
          end
        end
      end
      ACTIVE: begin
        // A VSYNC rise ends the frame outright; a half-built pixel is simply dropped.
        if (cam.VSYNC) begin
          state_d = VBLANK;
          eof_d   = 1'b1;
          fcnt_d  = fcnt_q + 16'd1;
          idx_d   = '0;
        end else if (cam.HREF) begin
          acc_d = asm_pix;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            x_d   = sat_inc(x_q);
            if (in_win) begin
              valid_d    = 1'b1;
              pixel_d    = asm_pix;
              px_d       = x_q;
              py_d       = y_q;
              sof_d      = sof_pend_q;
              sof_pend_d = 1'b0;
              eol_d      = (x_q == xe_q);
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (href_q) begin
          y_d = sat_inc(y_q);
          x_d = '0;
          if (idx_q != '0) begin
            lerr_d = 1'b1;
            idx_d  = '0;
          end
        end
      end
      SKIP: begin
        if (cam.VSYNC) state_d = VBLANK;
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= SYNC;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sof_pend_q <= 1'b0;
      href_q     <= 1'b0;
      pixel_q    <= '0;
      px_q       <= '0;
      py_q       <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      lerr_q     <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sof_pend_q <= sof_pend_d;
      href_q     <= cam.HREF;
      pixel_q    <= pixel_d;
      px_q       <= px_d;
      py_q       <= py_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      eof_q      <= eof_d;
      lerr_q     <= lerr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Byte accumulator and latched bounds are always rewritten before use.
  always_ff @(posedge i_pclk) begin
    acc_q <= acc_d;
    xs_q  <= xs_d;
    xe_q  <= xe_d;
    ys_q  <= ys_d;
    ye_q  <= ye_d;
  end

  assign cam.o_pixel = pixel_q;
  assign cam.o_valid = valid_q;
  assign cam.o_x     = px_q;
  assign cam.o_y     = py_q;
  assign cam.o_sof   = sof_q;
  assign cam.o_eol   = eol_q;
  assign o_eof       = eof_q;
  assign o_line_err  = lerr_q;
  assign o_frame_cnt = fcnt_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Bench for cam_pixel_capture: RGB565 (u0) and 3-byte swapped (u1) instances share one sensor stream.
module tb_cam_pixel_capture;

  typedef struct packed {
    logic [31:0] pix;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic        eol;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable;
  logic [11:0] i_x_start, i_x_end, i_y_start, i_y_end;
  logic        eof0, lerr0, eof1, lerr1;
  logic [15:0] fcnt0, fcnt1;

  cam_pixel_capture_if #(.DATA_W(8), .BYTES_PER_PIX(2), .CNT_W(12)) if0 ();
  cam_pixel_capture_if #(.DATA_W(8), .BYTES_PER_PIX(3), .CNT_W(12)) if1 ();

  assign if1.CAM_DATA = if0.CAM_DATA;
  assign if1.HREF     = if0.HREF;
  assign if1.VSYNC    = if0.VSYNC;

  cam_pixel_capture #(.DATA_W(8), .BYTES_PER_PIX(2), .BYTE_SWAP(0), .CNT_W(12)) u0 (
    .i_pclk(clk), .i_rst_n(rst_n), .cam(if0), .i_enable(i_enable),
    .i_x_start(i_x_start), .i_x_end(i_x_end), .i_y_start(i_y_start), .i_y_end(i_y_end),
    .o_eof(eof0), .o_line_err(lerr0), .o_frame_cnt(fcnt0));

  cam_pixel_capture #(.DATA_W(8), .BYTES_PER_PIX(3), .BYTE_SWAP(1), .CNT_W(12)) u1 (
    .i_pclk(clk), .i_rst_n(rst_n), .cam(if1), .i_enable(i_enable),
    .i_x_start(i_x_start), .i_x_end(i_x_end), .i_y_start(i_y_start), .i_y_end(i_y_end),
    .o_eof(eof1), .o_line_err(lerr1), .o_frame_cnt(fcnt1));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  pix_t obs0[$], obs1[$], exp0[$], exp1[$], mq[$];
  int   n_eof0 = 0, n_lerr0 = 0, n_eof1 = 0, n_lerr1 = 0, consec0 = 0, consec1 = 0;
  logic prev_v0 = 1'b0, prev_v1 = 1'b0;

  logic [7:0] line_bytes[8][16];
  int         line_len[8];
  int         n_lines;
  int         wxs, wxe, wys, wye;
  int         m_lerr, lerr_exp0, lerr_exp1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.o_valid) obs0.push_back('{pix:32'(if0.o_pixel), x:if0.o_x, y:if0.o_y, sof:if0.o_sof, eol:if0.o_eol});
      if (if1.o_valid) obs1.push_back('{pix:32'(if1.o_pixel), x:if1.o_x, y:if1.o_y, sof:if1.o_sof, eol:if1.o_eol});
      if (eof0)  n_eof0  <= n_eof0 + 1;
      if (eof1)  n_eof1  <= n_eof1 + 1;
      if (lerr0) n_lerr0 <= n_lerr0 + 1;
      if (lerr1) n_lerr1 <= n_lerr1 + 1;
      if (if0.o_valid && prev_v0) consec0 <= consec0 + 1;
      if (if1.o_valid && prev_v1) consec1 <= consec1 + 1;
      prev_v0 <= if0.o_valid;
      prev_v1 <= if1.o_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_window(input int xs, input int xe, input int ys, input int ye);
    wxs = xs; wxe = xe; wys = ys; wye = ye;
    i_x_start = 12'(xs); i_x_end = 12'(xe); i_y_start = 12'(ys); i_y_end = 12'(ye);
  endtask

  task automatic counting_lines(input int nl, input int len);
    n_lines = nl;
    for (int l = 0; l < nl; l++) begin
      line_len[l] = len;
      for (int b = 0; b < len; b++) line_bytes[l][b] = 8'(b + 1);
    end
  endtask

  // Expected emissions of one frame, derived from bytes per line and the crop window.
  task automatic model_frame(input int bpp, input bit swap, input bit en);
    bit          first;
    logic [31:0] v;
    int          sh;
    mq.delete();
    m_lerr = 0;
    if (en) begin
      first = 1'b1;
      for (int l = 0; l < n_lines; l++) begin
        if (line_len[l] % bpp != 0) m_lerr++;
        for (int p = 0; p < line_len[l] / bpp; p++) begin
          v = 0;
          for (int b = 0; b < bpp; b++) begin
            sh = swap ? 8 * b : 8 * (bpp - 1 - b);
            v  = v | (32'(line_bytes[l][p*bpp+b]) << sh);
          end
          if (p >= wxs && p <= wxe && l >= wys && l <= wye) begin
            mq.push_back('{pix:v, x:12'(p), y:12'(l), sof:first, eol:(p == wxe)});
            first = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic build_expect(input bit en);
    model_frame(2, 1'b0, en); exp0 = mq; lerr_exp0 = m_lerr;
    model_frame(3, 1'b1, en); exp1 = mq; lerr_exp1 = m_lerr;
  endtask

  task automatic drive_frame(input bit en);
    i_enable = en;
    if0.HREF = 1'b0;
    if0.VSYNC = 1'b1;
    repeat (3) tick();
    if0.VSYNC = 1'b0;
    repeat (2) tick();
    // Enable and bounds wander mid-frame; the frame in flight must ignore them.
    i_enable  = 1'($urandom_range(0, 1));
    i_x_start = 12'($urandom_range(0, 15));
    i_y_end   = 12'($urandom_range(0, 15));
    for (int l = 0; l < n_lines; l++) begin
      for (int b = 0; b < line_len[l]; b++) begin
        if0.HREF = 1'b1;
        if0.CAM_DATA = line_bytes[l][b];
        tick();
      end
      if0.HREF = 1'b0;
      if0.CAM_DATA = 8'($urandom);
      repeat (2) tick();
    end
    tick();
    if0.VSYNC = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_enable = 1'b1;
    set_window(0, 15, 0, 15);
    if0.CAM_DATA = 8'h5A; if0.HREF = 1'b1; if0.VSYNC = 1'b0;
    repeat (3) tick();
    total++; if (if0.o_pixel !== 16'h0)  begin bad++; $display("FAIL reset_pixel0 got=%h want=0", if0.o_pixel); end
    total++; if (if0.o_valid !== 1'b0)   begin bad++; $display("FAIL reset_valid0 got=%b want=0", if0.o_valid); end
    total++; if (fcnt0 !== 16'h0)        begin bad++; $display("FAIL reset_fcnt0 got=%0d want=0", fcnt0); end
    total++; if ({eof0, lerr0, if0.o_sof, if0.o_eol} !== 4'b0) begin bad++; $display("FAIL reset_flags0 got=%b want=0000", {eof0, lerr0, if0.o_sof, if0.o_eol}); end
    total++; if (if1.o_pixel !== 24'h0)  begin bad++; $display("FAIL reset_pixel1 got=%h want=0", if1.o_pixel); end
    rst_n = 1'b1;
    obs0.delete(); obs1.delete();
    for (int i = 0; i < 8; i++) begin
      if0.HREF = 1'(i % 2); if0.CAM_DATA = 8'($urandom);
      tick();
    end
    total++; if (obs0.size() + obs1.size() != 0) begin bad++; $display("FAIL reset_no_pix got=%0d want=0", obs0.size() + obs1.size()); end
  endtask

  task automatic test_rgb565_basic();
    int e0;
    e0 = n_eof0;
    set_window(0, 3, 0, 1);
    counting_lines(2, 8);
    build_expect(1'b1);
    obs0.delete(); obs1.delete();
    drive_frame(1'b1);
    total++; if (obs0.size() != exp0.size()) begin bad++; $display("FAIL basic_n0 got=%0d want=%0d", obs0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
      total++; if (obs0[i] !== exp0[i]) begin bad++; $display("FAIL basic_pix0[%0d] got=%h want=%h", i, obs0[i], exp0[i]); end
    end
    total++; if (obs1.size() != exp1.size()) begin bad++; $display("FAIL basic_n1 got=%0d want=%0d", obs1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      total++; if (obs1[i] !== exp1[i]) begin bad++; $display("FAIL basic_pix1[%0d] got=%h want=%h", i, obs1[i], exp1[i]); end
    end
    total++; if (obs0.size() != 8 || obs0[0].pix !== 32'h0102 || obs0[7].pix !== 32'h0708 || !obs0[3].eol)
      begin bad++; $display("FAIL basic_const got=n%0d/%h want=n8/0102", obs0.size(), obs0[0].pix); end
    total++; if (n_eof0 - e0 != 1) begin bad++; $display("FAIL basic_eof got=%0d want=1", n_eof0 - e0); end
    total++; if (fcnt0 !== 16'd1)  begin bad++; $display("FAIL basic_fcnt got=%0d want=1", fcnt0); end
    total++; if (consec0 != 0 || consec1 != 0) begin bad++; $display("FAIL basic_consec got=%0d/%0d want=0/0", consec0, consec1); end
  endtask

  task automatic test_bpp3_swap();
    int l0, l1;
    l0 = n_lerr0; l1 = n_lerr1;
    set_window(0, 15, 0, 15);
    i_enable = 1'b1;
    if0.VSYNC = 1'b1; repeat (3) tick();
    if0.VSYNC = 1'b0; repeat (2) tick();
    if0.HREF = 1'b1;
    if0.CAM_DATA = 8'hAA; tick();
    if0.CAM_DATA = 8'hBB; tick();
    if0.CAM_DATA = 8'hCC; tick();
    total++; if (if1.o_valid !== 1'b1 || if1.o_pixel !== 24'hCCBBAA)
      begin bad++; $display("FAIL bpp3_pix got=%b/%h want=1/ccbbaa", if1.o_valid, if1.o_pixel); end
    total++; if (if1.o_sof !== 1'b1 || if1.o_x !== 12'd0) begin bad++; $display("FAIL bpp3_sof got=%b/%0d want=1/0", if1.o_sof, if1.o_x); end
    if0.HREF = 1'b0; tick();
    total++; if (if1.o_valid !== 1'b0) begin bad++; $display("FAIL bpp3_pulse got=%b want=0", if1.o_valid); end
    tick();
    if0.VSYNC = 1'b1; repeat (2) tick();
    total++; if (n_lerr0 - l0 != 1 || n_lerr1 - l1 != 0)
      begin bad++; $display("FAIL bpp3_lerr got=%0d/%0d want=1/0", n_lerr0 - l0, n_lerr1 - l1); end
  endtask

  task automatic test_crop();
    set_window(2, 3, 1, 1);
    counting_lines(3, 8);
    for (int l = 0; l < 3; l++) for (int b = 0; b < 8; b++) line_bytes[l][b] = 8'($urandom);
    build_expect(1'b1);
    obs0.delete(); obs1.delete();
    drive_frame(1'b1);
    total++; if (obs0.size() != exp0.size()) begin bad++; $display("FAIL crop_n0 got=%0d want=%0d", obs0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
      total++; if (obs0[i] !== exp0[i]) begin bad++; $display("FAIL crop_pix0[%0d] got=%h want=%h", i, obs0[i], exp0[i]); end
    end
    total++; if (obs0.size() != 2 || obs0[0].x !== 12'd2 || obs0[0].y !== 12'd1 || !obs0[0].sof || obs0[1].sof)
      begin bad++; $display("FAIL crop_const got=n%0d x%0d y%0d want=n2 x2 y1", obs0.size(), obs0[0].x, obs0[0].y); end
  endtask

  task automatic test_line_err();
    int l0;
    l0 = n_lerr0;
    set_window(0, 7, 0, 3);
    n_lines = 2; line_len[0] = 3; line_len[1] = 8;
    for (int b = 0; b < 8; b++) begin line_bytes[0][b] = 8'($urandom); line_bytes[1][b] = 8'($urandom); end
    build_expect(1'b1);
    obs0.delete(); obs1.delete();
    drive_frame(1'b1);
    total++; if (obs0.size() != exp0.size()) begin bad++; $display("FAIL lerr_n0 got=%0d want=%0d", obs0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
      total++; if (obs0[i] !== exp0[i]) begin bad++; $display("FAIL lerr_pix0[%0d] got=%h want=%h", i, obs0[i], exp0[i]); end
    end
    total++; if (n_lerr0 - l0 != 1) begin bad++; $display("FAIL lerr_count got=%0d want=1", n_lerr0 - l0); end
    total++; if (obs0.size() != 5 || obs0[1].x !== 12'd0 || obs0[1].y !== 12'd1)
      begin bad++; $display("FAIL lerr_next_line got=x%0d y%0d want=x0 y1", obs0[1].x, obs0[1].y); end
  endtask

  task automatic test_enable();
    int e0;
    logic [15:0] f0;
    e0 = n_eof0; f0 = fcnt0;
    set_window(0, 7, 0, 7);
    counting_lines(2, 6);
    obs0.delete(); obs1.delete();
    drive_frame(1'b0);
    total++; if (obs0.size() + obs1.size() != 0 || n_eof0 != e0)
      begin bad++; $display("FAIL en_off got=pix%0d eof%0d want=0/0", obs0.size() + obs1.size(), n_eof0 - e0); end
    set_window(0, 7, 0, 7);
    build_expect(1'b1);
    drive_frame(1'b1);
    total++; if (obs0.size() != exp0.size()) begin bad++; $display("FAIL en_on_n0 got=%0d want=%0d", obs0.size(), exp0.size()); end
    total++; if (fcnt0 - f0 != 16'd1 || n_eof0 - e0 != 1)
      begin bad++; $display("FAIL en_fcnt got=%0d/%0d want=1/1", fcnt0 - f0, n_eof0 - e0); end
  endtask

  task automatic test_empty_crop();
    int e0;
    logic [15:0] f0;
    e0 = n_eof0; f0 = fcnt0;
    set_window(3, 1, 0, 3);
    counting_lines(2, 8);
    obs0.delete(); obs1.delete();
    drive_frame(1'b1);
    total++; if (obs0.size() + obs1.size() != 0) begin bad++; $display("FAIL empty_pix got=%0d want=0", obs0.size() + obs1.size()); end
    total++; if (n_eof0 - e0 != 1 || fcnt0 - f0 != 16'd1)
      begin bad++; $display("FAIL empty_eof got=%0d/%0d want=1/1", n_eof0 - e0, fcnt0 - f0); end
  endtask

  task automatic test_vsync_mid_line();
    int l0, l1, e0;
    l0 = n_lerr0; l1 = n_lerr1; e0 = n_eof0;
    set_window(0, 15, 0, 15);
    i_enable = 1'b1;
    obs0.delete(); obs1.delete();
    if0.VSYNC = 1'b1; repeat (3) tick();
    if0.VSYNC = 1'b0; repeat (2) tick();
    if0.HREF = 1'b1;
    if0.CAM_DATA = 8'h11; tick();
    if0.CAM_DATA = 8'h22; tick();
    if0.CAM_DATA = 8'h33; tick();
    if0.CAM_DATA = 8'h44; if0.VSYNC = 1'b1; tick();
    if0.HREF = 1'b0; repeat (2) tick();
    total++; if (obs0.size() != 1 || obs0[0].pix !== 32'h1122) begin bad++; $display("FAIL vsync_pix0 got=n%0d/%h want=n1/1122", obs0.size(), obs0[0].pix); end
    total++; if (obs1.size() != 1 || obs1[0].pix !== 32'h332211) begin bad++; $display("FAIL vsync_pix1 got=n%0d/%h want=n1/332211", obs1.size(), obs1[0].pix); end
    total++; if (n_lerr0 != l0 || n_lerr1 != l1 || n_eof0 - e0 != 1)
      begin bad++; $display("FAIL vsync_flags got=lerr%0d/%0d eof%0d want=0/0/1", n_lerr0 - l0, n_lerr1 - l1, n_eof0 - e0); end
  endtask

  task automatic test_back_to_back();
    int e0, l0, l1, nf;
    logic [15:0] f0;
    bit en;
    for (int f = 0; f < 12; f++) begin
      e0 = n_eof0; l0 = n_lerr0; l1 = n_lerr1; f0 = fcnt0;
      set_window($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 4));
      n_lines = $urandom_range(1, 4);
      for (int l = 0; l < n_lines; l++) begin
        line_len[l] = $urandom_range(1, 12);
        for (int b = 0; b < 16; b++) line_bytes[l][b] = 8'($urandom);
      end
      en = ($urandom_range(0, 3) != 0);
      nf = en ? 1 : 0;
      build_expect(en);
      obs0.delete(); obs1.delete();
      drive_frame(en);
      total++; if (obs0.size() != exp0.size() || obs1.size() != exp1.size())
        begin bad++; $display("FAIL rnd%0d_n got=%0d/%0d want=%0d/%0d", f, obs0.size(), obs1.size(), exp0.size(), exp1.size()); end
      for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
        total++; if (obs0[i] !== exp0[i]) begin bad++; $display("FAIL rnd%0d_pix0[%0d] got=%h want=%h", f, i, obs0[i], exp0[i]); end
      end
      for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
        total++; if (obs1[i] !== exp1[i]) begin bad++; $display("FAIL rnd%0d_pix1[%0d] got=%h want=%h", f, i, obs1[i], exp1[i]); end
      end
      total++; if (n_lerr0 - l0 != lerr_exp0 || n_lerr1 - l1 != lerr_exp1)
        begin bad++; $display("FAIL rnd%0d_lerr got=%0d/%0d want=%0d/%0d", f, n_lerr0 - l0, n_lerr1 - l1, lerr_exp0, lerr_exp1); end
      total++; if (n_eof0 - e0 != nf || int'(fcnt0 - f0) != nf || fcnt1 !== fcnt0)
        begin bad++; $display("FAIL rnd%0d_frame got=eof%0d cnt%0d want=%0d", f, n_eof0 - e0, fcnt0 - f0, nf); end
    end
    total++; if (consec0 != 0 || consec1 != 0) begin bad++; $display("FAIL rnd_consec got=%0d/%0d want=0/0", consec0, consec1); end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    set_window(0, 15, 0, 15);
    i_enable = 1'b1;
    if0.VSYNC = 1'b1; repeat (3) tick();
    if0.VSYNC = 1'b0; repeat (2) tick();
    if0.HREF = 1'b1;
    for (int i = 0; i < 3; i++) begin if0.CAM_DATA = 8'($urandom); tick(); end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin if0.CAM_DATA = 8'($urandom); tick(); end
    total++; if (fcnt0 !== 16'd0 || if0.o_valid !== 1'b0) begin bad++; $display("FAIL rstmid_cnt got=%0d/%b want=0/0", fcnt0, if0.o_valid); end
    rst_n = 1'b1;
    obs0.delete(); obs1.delete();
    e0 = n_eof0;
    for (int i = 0; i < 5; i++) begin if0.CAM_DATA = 8'($urandom); tick(); end
    if0.HREF = 1'b0; repeat (2) tick();
    if0.HREF = 1'b1;
    for (int i = 0; i < 6; i++) begin if0.CAM_DATA = 8'($urandom); tick(); end
    if0.HREF = 1'b0; tick();
    if0.VSYNC = 1'b1; repeat (2) tick();
    total++; if (obs0.size() + obs1.size() != 0 || n_eof0 != e0 || fcnt0 !== 16'd0)
      begin bad++; $display("FAIL rstmid_silent got=pix%0d eof%0d cnt%0d want=0/0/0", obs0.size() + obs1.size(), n_eof0 - e0, fcnt0); end
    set_window(0, 15, 0, 15);
    counting_lines(2, 6);
    build_expect(1'b1);
    drive_frame(1'b1);
    total++; if (obs0.size() != exp0.size()) begin bad++; $display("FAIL rstmid_n0 got=%0d want=%0d", obs0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
      total++; if (obs0[i] !== exp0[i]) begin bad++; $display("FAIL rstmid_pix0[%0d] got=%h want=%h", i, obs0[i], exp0[i]); end
    end
    total++; if (fcnt0 !== 16'd1) begin bad++; $display("FAIL rstmid_fcnt got=%0d want=1", fcnt0); end
  endtask

  initial begin
    test_reset();
    test_rgb565_basic();
    test_bpp3_swap();
    test_crop();
    test_line_err();
    test_enable();
    test_empty_crop();
    test_vsync_mid_line();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
